// File: rtl/tlb_pkg.sv
// Shared definitions for the TLB maintenance sequencer: entry count,
// instruction encodings, controller states and the captured request record.
package tlb_pkg;

    localparam int unsigned TLB_NUM  = 16;
    localparam int unsigned TLB_IDXW = $clog2(TLB_NUM);

    // TLB maintenance instruction encodings; 5..7 are illegal.
    typedef enum logic [2:0] {
        OP_SRCH = 3'd0,
        OP_RD   = 3'd1,
        OP_WR   = 3'd2,
        OP_FILL = 3'd3,
        OP_INV  = 3'd4
    } op_type_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Largest INVTLB op value that is architecturally defined.
    localparam logic [4:0] INV_OP_MAX = 5'd6;

    // Request fields captured at accept (index-width fields live in the top).
    typedef struct packed {
        logic [2:0]  op;
        logic [4:0]  inv_op;
        logic [9:0]  inv_asid;
        logic [18:0] inv_vppn;
        logic        inv_bit12;
        logic [9:0]  asid;
        logic [18:0] vppn;
    } req_t;

    // True for op types outside the defined set and for INVTLB ops above INV_OP_MAX.
    function automatic logic op_illegal(input logic [2:0] op, input logic [4:0] inv_op);
        logic ill;
        ill = 1'b0;
        if (op > OP_INV) begin
            ill = 1'b1;
        end else if (op == OP_INV && inv_op > INV_OP_MAX) begin
            ill = 1'b1;
        end
        return ill;
    endfunction

endpackage

// File: rtl/tlb_fill_ptr.sv
// Free-running replacement pointer used by TLBFILL; wraps from NUM-1 to 0.
module tlb_fill_ptr
    import tlb_pkg::*;
#(
    parameter int unsigned NUM  = TLB_NUM,
    parameter int unsigned IDXW = $clog2(NUM)
) (
    input  logic            clk,
    input  logic            reset,
    output logic [IDXW-1:0] ptr
);

    // Advance every cycle, restarting at zero after reset and after NUM-1.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (ptr == IDXW'(NUM - 1)) begin
            ptr <= '0;
        end else begin
            ptr <= ptr + IDXW'(1);
        end
    end

endmodule

// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLB maintenance instructions (TLBSRCH/TLBRD/TLBWR/TLBFILL/
// INVTLB). Runs one instruction at a time through IDLE -> EXEC -> DONE,
// drives the TLB strobes in EXEC and borrows search port 1 from the memory
// stage for SRCH and INV.
module tlb_op_ctrl
    import tlb_pkg::*;
#(
    parameter int unsigned NUM  = TLB_NUM,
    parameter int unsigned IDXW = $clog2(NUM)
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            op_valid,
    output logic            op_ready,
    input  logic [2:0]      op_type,
    input  logic [4:0]      inv_op,
    input  logic [9:0]      inv_asid,
    input  logic [31:0]     inv_va,

    input  logic [9:0]      csr_asid,
    input  logic [18:0]     csr_vppn,
    input  logic [IDXW-1:0] csr_index,

    input  logic [18:0]     mem_vppn,
    input  logic            mem_va_bit12,
    input  logic [9:0]      mem_asid,
    output logic            mem_stall,

    output logic [18:0]     s1_vppn,
    output logic            s1_va_bit12,
    output logic [9:0]      s1_asid,
    input  logic            s1_found,
    input  logic [IDXW-1:0] s1_findex,

    output logic            tlb_we,
    output logic [IDXW-1:0] tlb_w_index,
    output logic [IDXW-1:0] tlb_r_index,
    output logic            invtlb_valid,
    output logic [4:0]      invtlb_op,

    output logic            done,
    output logic            srch_found,
    output logic [IDXW-1:0] srch_index,
    output logic            rd_latch,
    output logic            ine
);

    state_e          state_q;
    state_e          state_d;
    req_t            req_q;
    logic [IDXW-1:0] index_q;
    logic [IDXW-1:0] fill_q;
    logic [IDXW-1:0] fill_ptr;
    logic            ine_q;
    logic            accept;
    logic            in_exec;
    logic            in_done;
    logic            unused_va_low;

    // The page-offset bits of the INVTLB address never reach the TLB.
    assign unused_va_low = ^inv_va[11:0];

    tlb_fill_ptr #(
        .NUM  (NUM),
        .IDXW (IDXW)
    ) u_fill_ptr (
        .clk   (clk),
        .reset (reset),
        .ptr   (fill_ptr)
    );

    assign accept  = op_valid && op_ready && !reset;
    // A reset asserted mid-op suppresses that cycle's strobes and completion.
    assign in_exec = (state_q == ST_EXEC) && !reset;
    assign in_done = (state_q == ST_DONE) && !reset;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: each accepted op spends exactly one cycle in EXEC and one in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (op_valid) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the instruction and its CSR operands at accept so later CSR changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= '0;
            index_q <= '0;
            fill_q  <= '0;
        end else if (accept) begin
            req_q.op        <= op_type;
            req_q.inv_op    <= inv_op;
            req_q.inv_asid  <= inv_asid;
            req_q.inv_vppn  <= inv_va[31:13];
            req_q.inv_bit12 <= inv_va[12];
            req_q.asid      <= csr_asid;
            req_q.vppn      <= csr_vppn;
            index_q         <= csr_index;
            fill_q          <= fill_ptr;
        end
    end

    // Record the illegal-op flag and the search result at the end of EXEC; search results persist until the next SRCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            ine_q      <= 1'b0;
            srch_found <= 1'b0;
            srch_index <= '0;
        end else if (state_q == ST_EXEC) begin
            ine_q <= op_illegal(req_q.op, req_q.inv_op);
            if (req_q.op == OP_SRCH) begin
                srch_found <= s1_found;
                srch_index <= s1_findex;
            end
        end
    end

    // Outputs: per-op strobes and port-1 ownership in EXEC, completion pulse in DONE.
    always_comb begin
        op_ready     = (state_q == ST_IDLE);
        mem_stall    = 1'b0;
        s1_vppn      = mem_vppn;
        s1_va_bit12  = mem_va_bit12;
        s1_asid      = mem_asid;
        tlb_we       = 1'b0;
        tlb_w_index  = '0;
        tlb_r_index  = '0;
        rd_latch     = 1'b0;
        invtlb_valid = 1'b0;
        invtlb_op    = '0;
        done         = 1'b0;
        ine          = 1'b0;

        if (in_exec) begin
            case (req_q.op)
                OP_SRCH: begin
                    mem_stall   = 1'b1;
                    s1_vppn     = req_q.vppn;
                    s1_va_bit12 = 1'b0;
                    s1_asid     = req_q.asid;
                end
                OP_RD: begin
                    rd_latch    = 1'b1;
                    tlb_r_index = index_q;
                end
                OP_WR: begin
                    tlb_we      = 1'b1;
                    tlb_w_index = index_q;
                end
                OP_FILL: begin
                    tlb_we      = 1'b1;
                    tlb_w_index = fill_q;
                end
                OP_INV: begin
                    if (req_q.inv_op <= INV_OP_MAX) begin
                        mem_stall    = 1'b1;
                        s1_vppn      = req_q.inv_vppn;
                        s1_va_bit12  = req_q.inv_bit12;
                        s1_asid      = req_q.inv_asid;
                        invtlb_valid = 1'b1;
                        invtlb_op    = req_q.inv_op;
                    end
                end
                default: ;
            endcase
        end

        if (in_done) begin
            done = 1'b1;
            ine  = ine_q;
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Bench for tlb_op_ctrl: directed vector table, hand-written reset/fill
// sequences, then random instructions checked against a behavioural model
// of the TLB contents and the per-op rules.
module tb_tlb_op_ctrl;
    import tlb_pkg::*;

    localparam int unsigned NUM  = 16;
    localparam int unsigned IDXW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            op_valid = 1'b0;
    logic            op_ready;
    logic [2:0]      op_type = 3'd0;
    logic [4:0]      inv_op = 5'd0;
    logic [9:0]      inv_asid = 10'd0;
    logic [31:0]     inv_va = 32'd0;
    logic [9:0]      csr_asid = 10'd0;
    logic [18:0]     csr_vppn = 19'd0;
    logic [IDXW-1:0] csr_index = 4'd0;
    logic [18:0]     mem_vppn = 19'd0;
    logic            mem_va_bit12 = 1'b0;
    logic [9:0]      mem_asid = 10'd0;
    logic            mem_stall;
    logic [18:0]     s1_vppn;
    logic            s1_va_bit12;
    logic [9:0]      s1_asid;
    logic            s1_found;
    logic [IDXW-1:0] s1_findex;
    logic            tlb_we;
    logic [IDXW-1:0] tlb_w_index;
    logic [IDXW-1:0] tlb_r_index;
    logic            invtlb_valid;
    logic [4:0]      invtlb_op;
    logic            done;
    logic            srch_found;
    logic [IDXW-1:0] srch_index;
    logic            rd_latch;
    logic            ine;

    int checks = 0;
    int failures = 0;

    tlb_op_ctrl #(.NUM(NUM), .IDXW(IDXW)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_type      (op_type),
        .inv_op       (inv_op),
        .inv_asid     (inv_asid),
        .inv_va       (inv_va),
        .csr_asid     (csr_asid),
        .csr_vppn     (csr_vppn),
        .csr_index    (csr_index),
        .mem_vppn     (mem_vppn),
        .mem_va_bit12 (mem_va_bit12),
        .mem_asid     (mem_asid),
        .mem_stall    (mem_stall),
        .s1_vppn      (s1_vppn),
        .s1_va_bit12  (s1_va_bit12),
        .s1_asid      (s1_asid),
        .s1_found     (s1_found),
        .s1_findex    (s1_findex),
        .tlb_we       (tlb_we),
        .tlb_w_index  (tlb_w_index),
        .tlb_r_index  (tlb_r_index),
        .invtlb_valid (invtlb_valid),
        .invtlb_op    (invtlb_op),
        .done         (done),
        .srch_found   (srch_found),
        .srch_index   (srch_index),
        .rd_latch     (rd_latch),
        .ine          (ine)
    );

    always #5 clk = ~clk;

    // Cycle index since reset released; the fill pointer is this value mod NUM.
    int unsigned cyc = 0;
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // TLB array stand-in: written by the DUT's write strobe, searched on port 1 (lowest index wins).
    logic [18:0] tv   [NUM];
    logic [9:0]  ta   [NUM];
    logic        tvld [NUM];
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM); i++) tvld[i] <= 1'b0;
        end else if (tlb_we) begin
            tv[tlb_w_index]   <= csr_vppn;
            ta[tlb_w_index]   <= csr_asid;
            tvld[tlb_w_index] <= 1'b1;
        end
    end
    always_comb begin
        s1_found  = 1'b0;
        s1_findex = '0;
        for (int i = int'(NUM) - 1; i >= 0; i--) begin
            if (tvld[i] && tv[i] == s1_vppn && ta[i] == s1_asid) begin
                s1_found  = 1'b1;
                s1_findex = 4'(i);
            end
        end
    end

    // Reference model state: what the TLB should hold, and the last completed search.
    logic [18:0] mv   [NUM];
    logic [9:0]  ma   [NUM];
    logic        mvld [NUM];
    logic        last_found = 1'b0;
    logic [3:0]  last_fidx = 4'd0;

    typedef struct {
        logic [2:0]  ty;
        logic [4:0]  iop;
        logic [9:0]  iasid;
        logic [31:0] iva;
        logic [18:0] vppn;
        logic [9:0]  asid;
        logic [3:0]  idx;
        logic        we;
        logic [3:0]  widx;
        logic        rdl;
        logic [3:0]  ridx;
        logic        invv;
        logic [4:0]  invop;
        logic        stall;
        logic [18:0] s1v;
        logic        s1b;
        logic [9:0]  s1a;
        logic        ine;
        logic        found;
        logic [3:0]  fidx;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < int'(NUM); i++) mvld[i] = 1'b0;
        last_found = 1'b0;
        last_fidx  = 4'd0;
    endtask

    // Expected behaviour of one instruction, from the instruction rules and the model TLB.
    function automatic vec_t predict(input logic [2:0] ty, input logic [4:0] iop,
                                     input logic [9:0] iasid, input logic [31:0] iva,
                                     input logic [18:0] vppn, input logic [9:0] asid,
                                     input logic [3:0] idx, input logic [3:0] fill);
        vec_t v;
        v.ty = ty; v.iop = iop; v.iasid = iasid; v.iva = iva;
        v.vppn = vppn; v.asid = asid; v.idx = idx;
        v.we = 1'b0; v.widx = 4'd0; v.rdl = 1'b0; v.ridx = 4'd0;
        v.invv = 1'b0; v.invop = 5'd0; v.stall = 1'b0;
        v.s1v = 19'd0; v.s1b = 1'b0; v.s1a = 10'd0; v.ine = 1'b0;
        v.found = last_found; v.fidx = last_fidx;
        if (ty == 3'd0) begin
            v.stall = 1'b1; v.s1v = vppn; v.s1a = asid;
            v.found = 1'b0; v.fidx = 4'd0;
            for (int i = 0; i < int'(NUM); i++) begin
                if (!v.found && mvld[i] && mv[i] == vppn && ma[i] == asid) begin
                    v.found = 1'b1; v.fidx = 4'(i);
                end
            end
        end else if (ty == 3'd1) begin
            v.rdl = 1'b1; v.ridx = idx;
        end else if (ty == 3'd2) begin
            v.we = 1'b1; v.widx = idx;
        end else if (ty == 3'd3) begin
            v.we = 1'b1; v.widx = fill;
        end else if (ty == 3'd4 && iop <= 5'd6) begin
            v.invv = 1'b1; v.invop = iop; v.stall = 1'b1;
            v.s1v = iva[31:13]; v.s1b = iva[12]; v.s1a = iasid;
        end else begin
            v.ine = 1'b1;
        end
        return v;
    endfunction

    task automatic rand_mem();
        mem_vppn     = 19'($urandom);
        mem_va_bit12 = 1'($urandom);
        mem_asid     = 10'($urandom);
    endtask

    // Issue one instruction starting in an IDLE cycle; returns in the next accept-capable cycle.
    task automatic run_op(input vec_t v, input bit hold, input bit rnd);
        if (rnd) rand_mem();
        op_type = v.ty; inv_op = v.iop; inv_asid = v.iasid; inv_va = v.iva;
        csr_vppn = v.vppn; csr_asid = v.asid; csr_index = v.idx;
        op_valid = 1'b1;
        #1;
        chk("accept_ready", 32'(op_ready), 32'd1);
        chk("accept_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); @(negedge clk);
        if (rnd) rand_mem();
        if (hold) begin op_type = 3'($urandom); inv_op = 5'($urandom); end
        else op_valid = 1'b0;
        #1;
        chk("exec_ready", 32'(op_ready), 32'd0);
        chk("exec_we", 32'(tlb_we), 32'(v.we));
        if (v.we) chk("exec_widx", 32'(tlb_w_index), 32'(v.widx));
        chk("exec_rd_latch", 32'(rd_latch), 32'(v.rdl));
        if (v.rdl) chk("exec_ridx", 32'(tlb_r_index), 32'(v.ridx));
        chk("exec_inv", 32'(invtlb_valid), 32'(v.invv));
        chk("exec_invop", 32'(invtlb_op), 32'(v.invop));
        chk("exec_stall", 32'(mem_stall), 32'(v.stall));
        chk("exec_s1_vppn", 32'(s1_vppn), 32'(v.stall ? v.s1v : mem_vppn));
        chk("exec_s1_b12", 32'(s1_va_bit12), 32'(v.stall ? v.s1b : mem_va_bit12));
        chk("exec_s1_asid", 32'(s1_asid), 32'(v.stall ? v.s1a : mem_asid));
        chk("exec_done", 32'(done), 32'd0);
        @(posedge clk); @(negedge clk);
        if (rnd) rand_mem();
        if (hold) op_type = 3'($urandom);
        #1;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_ine", 32'(ine), 32'(v.ine));
        chk("done_found", 32'(srch_found), 32'(v.found));
        chk("done_index", 32'(srch_index), 32'(v.fidx));
        chk("done_strobes", 32'({tlb_we, rd_latch, invtlb_valid}), 32'd0);
        chk("done_stall", 32'(mem_stall), 32'd0);
        chk("done_s1_vppn", 32'(s1_vppn), 32'(mem_vppn));
        chk("done_ready", 32'(op_ready), 32'd0);
        @(posedge clk); @(negedge clk);
        op_valid = 1'b0;
        if (rnd) rand_mem();
        #1;
        chk("idle_ready", 32'(op_ready), 32'd1);
        chk("idle_done", 32'(done), 32'd0);
        chk("idle_found", 32'(srch_found), 32'(v.found));
        if (v.ty == 3'd2 || v.ty == 3'd3) begin
            mv[v.widx] = v.vppn; ma[v.widx] = v.asid; mvld[v.widx] = 1'b1;
        end
        if (v.ty == 3'd0) begin
            last_found = v.found; last_fidx = v.fidx;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        op_valid = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        logic [2:0]  ty;
        logic [18:0] vp;
        logic [9:0]  as;

        // ty iop iasid iva vppn asid idx | we widx rdl ridx invv invop stall s1v s1b s1a ine found fidx
        tbl[0]  = '{3'd2, 5'd0, 10'h0, 32'h0, 19'h12345, 10'h3, 4'd5,
                    1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 19'h0, 1'b0, 10'h0, 1'b0, 1'b0, 4'd0};
        tbl[1]  = '{3'd0, 5'd0, 10'h0, 32'h0, 19'h12345, 10'h3, 4'd0,
                    1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b1, 19'h12345, 1'b0, 10'h3, 1'b0, 1'b1, 4'd5};
        tbl[2]  = '{3'd2, 5'd0, 10'h0, 32'h0, 19'h0aaaa, 10'h10, 4'd9,
                    1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 19'h0, 1'b0, 10'h0, 1'b0, 1'b1, 4'd5};
        tbl[3]  = '{3'd1, 5'd0, 10'h0, 32'h0, 19'h0, 10'h0, 4'd9,
                    1'b0, 4'd0, 1'b1, 4'd9, 1'b0, 5'd0, 1'b0, 19'h0, 1'b0, 10'h0, 1'b0, 1'b1, 4'd5};
        tbl[4]  = '{3'd4, 5'd5, 10'h7, 32'h00402000, 19'h0, 10'h0, 4'd0,
                    1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 5'd5, 1'b1, 19'h00201, 1'b0, 10'h7, 1'b0, 1'b1, 4'd5};
        tbl[5]  = '{3'd4, 5'd7, 10'h1, 32'h12345678, 19'h0, 10'h0, 4'd0,
                    1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 19'h0, 1'b0, 10'h0, 1'b1, 1'b1, 4'd5};
        tbl[6]  = '{3'd6, 5'd0, 10'h0, 32'h0, 19'h0, 10'h0, 4'd0,
                    1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 19'h0, 1'b0, 10'h0, 1'b1, 1'b1, 4'd5};
        tbl[7]  = '{3'd0, 5'd0, 10'h0, 32'h0, 19'h0aaaa, 10'h10, 4'd0,
                    1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b1, 19'h0aaaa, 1'b0, 10'h10, 1'b0, 1'b1, 4'd9};
        tbl[8]  = '{3'd0, 5'd0, 10'h0, 32'h0, 19'h0aaaa, 10'h11, 4'd0,
                    1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b1, 19'h0aaaa, 1'b0, 10'h11, 1'b0, 1'b0, 4'd0};
        tbl[9]  = '{3'd4, 5'd0, 10'h3ff, 32'hfffff000, 19'h0, 10'h0, 4'd0,
                    1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 5'd0, 1'b1, 19'h7ffff, 1'b1, 10'h3ff, 1'b0, 1'b0, 4'd0};
        tbl[10] = '{3'd2, 5'd0, 10'h0, 32'h0, 19'h00001, 10'h1, 4'd15,
                    1'b1, 4'd15, 1'b0, 4'd0, 1'b0, 5'd0, 1'b0, 19'h0, 1'b0, 10'h0, 1'b0, 1'b0, 4'd0};
        tbl[11] = '{3'd0, 5'd0, 10'h0, 32'h0, 19'h00001, 10'h1, 4'd0,
                    1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 5'd0, 1'b1, 19'h00001, 1'b0, 10'h1, 1'b0, 1'b1, 4'd15};

        mem_vppn = 19'h7abcd; mem_va_bit12 = 1'b1; mem_asid = 10'h2aa;
        do_reset();
        #1;
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_done_ine", 32'({done, ine}), 32'd0);
        chk("rst_strobes", 32'({tlb_we, rd_latch, invtlb_valid, mem_stall}), 32'd0);
        chk("rst_srch", 32'({srch_found, srch_index}), 32'd0);
        chk("rst_indices", 32'({tlb_w_index, tlb_r_index, invtlb_op}), 32'd0);
        chk("rst_s1", 32'({s1_vppn, s1_va_bit12, s1_asid}), 32'({mem_vppn, mem_va_bit12, mem_asid}));

        for (int i = 0; i < 12; i++) run_op(tbl[i], (i % 3) == 1, 1'b0);

        // FILL index follows the free-running pointer: cycles 20 and 23 after reset.
        do_reset();
        repeat (20) @(negedge clk);
        v = predict(3'd3, 5'd0, 10'd0, 32'd0, 19'h00777, 10'h5, 4'd0, 4'd4);
        run_op(v, 1'b0, 1'b0);
        v = predict(3'd3, 5'd0, 10'd0, 32'd0, 19'h00778, 10'h5, 4'd0, 4'd7);
        run_op(v, 1'b0, 1'b0);

        // Reset during EXEC of a WR aborts it and restarts the fill pointer.
        do_reset();
        repeat (5) @(negedge clk);
        op_type = 3'd2; csr_index = 4'd3; csr_vppn = 19'h00123; csr_asid = 10'h9;
        op_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        op_valid = 1'b0; reset = 1'b1;
        #1;
        chk("rst_exec_we", 32'(tlb_we), 32'd0);
        chk("rst_exec_done", 32'(done), 32'd0);
        chk("rst_exec_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0; clear_model();
        #1;
        chk("rst_exec_ready", 32'(op_ready), 32'd1);
        chk("rst_exec_done2", 32'(done), 32'd0);
        v = predict(3'd3, 5'd0, 10'd0, 32'd0, 19'h00321, 10'h4, 4'd0, 4'd0);
        run_op(v, 1'b0, 1'b0);

        // Reset during DONE suppresses the completion pulse.
        op_type = 3'd6; op_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        op_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_done_pulse", 32'({done, ine}), 32'd0);
        @(posedge clk); @(negedge clk);
        reset = 1'b0; clear_model();
        #1;
        chk("rst_done_ready", 32'(op_ready), 32'd1);
        chk("rst_done_after", 32'(done), 32'd0);

        // Random instructions against the model, small key pools so searches hit.
        for (int n = 0; n < 250; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                rand_mem();
            end
            ty = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) ty = 3'd0;
            vp = 19'($urandom_range(0, 3)) + 19'h00100;
            as = 10'($urandom_range(1, 2));
            v = predict(ty, 5'($urandom_range(0, 8)), 10'($urandom), $urandom,
                        vp, as, 4'($urandom), 4'(cyc % NUM));
            run_op(v, 1'($urandom_range(0, 1)), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
